uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Configurable UART transmitter: the next-generation TX for the system's UART path. It replaces the fixed 8-bit, one-bit-per-clock transmitter with a run-time frame format (data length, parity, 1/2 stop bits) and an internal bit-rate prescaler. It adds a one-entry holding register with a valid/ready handshake, so that frames can be streamed back-to-back with no idle gap. It sits between the register-file/FIFO read side and the TX pin.

## Interface
- MAX_W, default 8, maximum data bits per frame; legal range 5..9.
- PRESC_W, default 6, width of the PRESCALE input.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DATA_IN  in  MAX_W  frame payload; sent LSB first.
- DATA_LEN  in  4  data bits per frame; values <5 are treated as 5, values >MAX_W as MAX_W.
- PAR_EN  in  1  1 = parity bit inserted after the data bits.
- PAR_TYPE  in  1  0 = even, 1 = odd.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- PRESCALE  in  PRESC_W  each line bit lasts PRESCALE+1 clocks.
- DATA_VALID  in  1  producer offers DATA_IN plus config.
- DATA_READY  out  1  holding register empty; transfer occurs on DATA_VALID & DATA_READY at a CLK edge.
- SER_OUT  out  1  serial line, registered; idle = 1.
- BUSY  out  1  a frame is on the line or pending in the holding register.
- FRAME_DONE  out  1  one-clock pulse in the last clock of each frame's final stop bit.

## Operation
- Config (DATA_LEN, PAR_EN, PAR_TYPE, STOP2, PRESCALE) is captured together with DATA_IN at acceptance. Changing inputs afterwards has no effect on that frame.
- Each frame is: start (0), L data bits LSB first, optional parity bit, then 1 or 2 stop bits (1). Bits of DATA_IN at or above index L are ignored.
- Parity is computed over the L data bits only:
  - even: parity bit = XOR of the data bits.
  - odd: parity bit = inverted XOR of the data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: on acceptance (bypass) or when the holding register is valid.
  - START → DATA: at bit end.
  - DATA → DATA: repeats until bit counter = L-1, then → PARITY if PAR_EN, else → STOP.
  - PARITY → STOP: at bit end.
  - STOP → STOP: second stop bit if STOP2.
  - Last stop bit end → START if the holding register is valid, else → IDLE.
- Bit end occurs when the prescale counter reaches the captured PRESCALE. The counter reloads to 0 at every bit end.
- Holding register:
  - Bypass: acceptance while IDLE with the holding register empty loads the shifter directly.
  - Acceptance while a frame is active fills the holding register; DATA_READY then drops.
  - The holding register drains into the shifter at the last-stop-bit end. DATA_READY rises in the following cycle.
- Reset behaviour:
  - Reset values: SER_OUT=1, BUSY=0, DATA_READY=1, FRAME_DONE=0; state IDLE; holding register empty; counters 0.
  - Reset mid-frame aborts the frame and discards the held word. SER_OUT is 1 from the first edge with RST high. DATA_READY stays 0 while RST is high and is 1 on the first cycle after RST falls.
- DATA_VALID while DATA_READY=0 is not a transfer; the producer holds its data.

## Timing
- Latency: acceptance at edge E0 from IDLE with holding empty gives SER_OUT=0 and BUSY=1 after E0.
- Frame length in clocks = (1 + L + PAR_EN + 1 + STOP2) × (PRESCALE+1).
- Back-to-back frames: the next start bit begins the clock immediately after the previous FRAME_DONE clock, with zero idle bits.
- BUSY falls after the last stop bit only if the holding register is empty. It stays 1 continuously across back-to-back frames.
- PRESCALE=0: one clock per bit, which is line-compatible with the previous-generation TX.
- Simultaneous drain and accept at the same edge: the held word moves to the shifter and the new word enters the holding register. DATA_READY stays 0 for that edge.

## Structure
- Package uart_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants MIN_LEN=5, START_BIT=0, STOP_BIT=1, LINE_IDLE=1;
  - a function that clamps DATA_LEN.
- Sub-module uart_tx_baud_cnt: PRESC_W prescale counter with a load/clear input and a bit_end output.
- The top level contains the FSM, shifter, bit counter, parity register and holding register.

## Test plan
- 8N1, PRESCALE=0, DATA_IN=0xA5 → SER_OUT 0,1,0,1,0,0,1,0,1,1; BUSY high exactly 10 clocks; one FRAME_DONE pulse.
- 7E2, PRESCALE=3, DATA_IN=0x53 (L=7) → start, 1,1,0,0,1,0,1, parity 0, stop, stop; each bit 4 clocks; frame 44 clocks.
- Odd parity, DATA_LEN=5, DATA_IN=0xFF → data 1,1,1,1,1, parity 0. Same input with DATA_LEN=2 (clamped to 5) gives an identical waveform.
- Two words 0x01, 0x80 offered continuously at 8N1 → DATA_READY drops after the second acceptance; second start bit immediately follows the first stop bit; BUSY high 20 clocks.
- RST asserted during data bit 3 with a word held → SER_OUT=1 and BUSY=0 the next clock; no further start bit; DATA_READY=1 after release.
- Config inputs toggled mid-frame → the current frame is unaffected; a frame accepted later uses the new config.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [3:0] MIN_LEN   = 4'd5;
    localparam logic       START_BIT = 1'b0;
    localparam logic       STOP_BIT  = 1'b1;
    localparam logic       LINE_IDLE = 1'b1;

    // Widest payload any instance can be built with; helpers work on this width.
    localparam int MAX_LEN_LIMIT = 9;

    // Frame format captured alongside a word.
    typedef struct packed {
        logic [3:0] len;
        logic       par_en;
        logic       par_type;
        logic       stop2;
    } frame_cfg_t;

    // Clamp a requested data length into MIN_LEN..max_len.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < MIN_LEN) begin
            return MIN_LEN;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    // XOR of the low 'len' bits of dat; bits at or above len do not contribute.
    function automatic logic data_parity(input logic [MAX_LEN_LIMIT-1:0] dat, input logic [3:0] len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_LEN_LIMIT; i++) begin
            if (4'(i) < len) begin
                p = p ^ dat[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period prescaler: flags the last clock of each line bit.
// Latency: bit_end is combinational from the counter; one bit = presc+1 clocks.
// Backpressure: none; held at zero while run is low or clear is high.
// Ports: clk/rst (sync, active-high), run (frame active), clear (start a new bit
// period), presc (captured prescale value), bit_end (last clock of current bit).
module uart_tx_baud_cnt #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_end
);

    logic [PRESC_W-1:0] cnt_q;

    assign bit_end = run & (cnt_q == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || !run || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time frame format, bit-rate prescaler and a one-word holding register.
// Latency: accepted word from idle drives its start bit on SER_OUT the clock after acceptance.
// Backpressure: DATA_READY low while the holding register is full or RST is high; producer holds.
// Ports: CLK, RST (sync, active-high); DATA_IN + DATA_LEN/PAR_EN/PAR_TYPE/STOP2/PRESCALE
// captured on DATA_VALID & DATA_READY; SER_OUT registered line (idle 1); BUSY frame on
// line or pending; FRAME_DONE pulse in the last clock of the final stop bit.
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int MAX_W   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [MAX_W-1:0]   DATA_IN,
    input  logic [3:0]         DATA_LEN,
    input  logic               PAR_EN,
    input  logic               PAR_TYPE,
    input  logic               STOP2,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic               DATA_VALID,
    output logic               DATA_READY,
    output logic               SER_OUT,
    output logic               BUSY,
    output logic               FRAME_DONE
);

    // Active frame state
    tx_state_t          state_q, state_d;
    logic [MAX_W-1:0]   sh_q, sh_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]         len_q, len_d;
    logic               par_en_q, par_en_d;
    logic               stop2_q, stop2_d;
    logic               par_q, par_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               ser_q, ser_d;

    // Holding register
    logic               hold_vld_q, hold_vld_d;
    logic [MAX_W-1:0]   hold_dat_q;
    frame_cfg_t         hold_cfg_q;
    logic [PRESC_W-1:0] hold_presc_q;

    frame_cfg_t                 in_cfg;
    logic [MAX_LEN_LIMIT-1:0]   in_ext, hold_ext;
    logic                       accept, load_new, load_hold, hold_load;
    logic                       bit_end, last_stop_end;

    uart_tx_baud_cnt #(.PRESC_W(PRESC_W)) u_baud (
        .clk     (CLK),
        .rst     (RST),
        .run     (state_q != IDLE),
        .clear   (load_new | load_hold),
        .presc   (presc_q),
        .bit_end (bit_end)
    );

    always_comb begin
        in_cfg.len      = clamp_len(DATA_LEN, 4'(MAX_W));
        in_cfg.par_en   = PAR_EN;
        in_cfg.par_type = PAR_TYPE;
        in_cfg.stop2    = STOP2;
        in_ext                = '0;
        in_ext[MAX_W-1:0]     = DATA_IN;
        hold_ext              = '0;
        hold_ext[MAX_W-1:0]   = hold_dat_q;
    end

    assign DATA_READY    = ~hold_vld_q & ~RST;
    assign accept        = DATA_VALID & DATA_READY;
    assign last_stop_end = (state_q == STOP) && bit_end && (!stop2_q || bit_cnt_q == 4'd1);

    assign SER_OUT    = ser_q;
    assign BUSY       = (state_q != IDLE) | hold_vld_q;
    assign FRAME_DONE = last_stop_end;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        par_d     = par_q;
        presc_d   = presc_q;
        load_new  = 1'b0;
        load_hold = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    load_hold = 1'b1;
                end else if (accept) begin
                    load_new = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == len_q - 4'd1) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sh_d      = sh_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (last_stop_end) begin
                    // A held word starts its start bit with no idle gap.
                    if (hold_vld_q) begin
                        load_hold = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_new) begin
            state_d   = START;
            sh_d      = DATA_IN;
            len_d     = in_cfg.len;
            par_en_d  = in_cfg.par_en;
            stop2_d   = in_cfg.stop2;
            par_d     = data_parity(in_ext, in_cfg.len) ^ in_cfg.par_type;
            presc_d   = PRESCALE;
            bit_cnt_d = '0;
        end else if (load_hold) begin
            state_d   = START;
            sh_d      = hold_dat_q;
            len_d     = hold_cfg_q.len;
            par_en_d  = hold_cfg_q.par_en;
            stop2_d   = hold_cfg_q.stop2;
            par_d     = data_parity(hold_ext, hold_cfg_q.len) ^ hold_cfg_q.par_type;
            presc_d   = hold_presc_q;
            bit_cnt_d = '0;
        end

        // Anything accepted that does not go straight to the shifter is held;
        // this also covers a drain and an accept on the same edge.
        hold_load  = accept & ~load_new;
        hold_vld_d = hold_load | (hold_vld_q & ~load_hold);

        // SER_OUT is registered, so the line level follows the next state.
        case (state_d)
            START:   ser_d = START_BIT;
            DATA:    ser_d = sh_d[0];
            PARITY:  ser_d = par_d;
            STOP:    ser_d = STOP_BIT;
            default: ser_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            len_q      <= MIN_LEN;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
            presc_q    <= '0;
            ser_q      <= LINE_IDLE;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            par_q      <= par_d;
            presc_q    <= presc_d;
            ser_q      <= ser_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    // Payload is qualified by hold_vld_q, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (hold_load) begin
            hold_dat_q   <= DATA_IN;
            hold_cfg_q   <= in_cfg;
            hold_presc_q <= PRESCALE;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: per-clock expected line levels are queued
// when a word is offered and popped against SER_OUT/BUSY/FRAME_DONE each clock.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [3:0] data_len;
    logic       par_en;
    logic       par_type;
    logic       stop2;
    logic [5:0] prescale;
    logic       data_valid;
    logic       data_ready;
    logic       ser_out;
    logic       busy;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit ser;
        bit busy;
        bit fd;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] l;
        bit         pe;
        bit         pt;
        bit         s2;
        logic [5:0] ps;
    } frm_t;

    exp_t exp_q[$];

    uart_tx_cfg #(.MAX_W(8), .PRESC_W(6)) dut (
        .CLK        (clk),
        .RST        (rst),
        .DATA_IN    (data_in),
        .DATA_LEN   (data_len),
        .PAR_EN     (par_en),
        .PAR_TYPE   (par_type),
        .STOP2      (stop2),
        .PRESCALE   (prescale),
        .DATA_VALID (data_valid),
        .DATA_READY (data_ready),
        .SER_OUT    (ser_out),
        .BUSY       (busy),
        .FRAME_DONE (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference model: expected line level for every clock of one frame.
    function automatic void push_frame(input frm_t f);
        int l;
        bit p;
        bit bits[$];
        exp_t e;
        l = (f.l < 4'd5) ? 5 : (f.l > 4'd8) ? 8 : int'(f.l);
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < l; i++) begin
            bits.push_back(f.d[i]);
            p = p ^ f.d[i];
        end
        if (f.pe) bits.push_back(f.pt ? ~p : p);
        bits.push_back(1'b1);
        if (f.s2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c <= int'(f.ps); c++) begin
                e.ser  = bits[b];
                e.busy = 1'b1;
                e.fd   = (b == bits.size() - 1) && (c == int'(f.ps));
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic set_in(input frm_t f);
        data_in  = f.d;
        data_len = f.l;
        par_en   = f.pe;
        par_type = f.pt;
        stop2    = f.s2;
        prescale = f.ps;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({ser_out, busy, frame_done} !== 3'b100) begin
            fails++;
            $display("FAIL reset_outputs: ser/busy/fd=%b%b%b expected 100", ser_out, busy, frame_done);
        end
        tests++;
        if (data_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_in_rst: data_ready=%b expected 0", data_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (data_ready !== 1'b1 || busy !== 1'b0 || ser_out !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: ready/busy/ser=%b%b%b expected 101", data_ready, busy, ser_out);
        end
    endtask

    task automatic test_formats();
        frm_t tbl[7];
        exp_t e;
        int   n;
        tbl[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 6'd0};  // 8N1
        tbl[1] = '{8'h53, 4'd7,  1'b1, 1'b0, 1'b1, 6'd3};  // 7E2
        tbl[2] = '{8'hFF, 4'd5,  1'b1, 1'b1, 1'b0, 6'd0};  // 5O1
        tbl[3] = '{8'hFF, 4'd2,  1'b1, 1'b1, 1'b0, 6'd0};  // clamped up to 5
        tbl[4] = '{8'h5A, 4'd15, 1'b1, 1'b0, 1'b1, 6'd2};  // clamped down to 8
        tbl[5] = '{8'h2B, 4'd6,  1'b0, 1'b0, 1'b1, 6'd1};
        tbl[6] = '{8'h96, 4'd8,  1'b1, 1'b1, 1'b1, 6'd0};
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            set_in(tbl[t]);
            data_valid = 1'b1;
            tests++;
            if (data_ready !== 1'b1) begin
                fails++;
                $display("FAIL fmt%0d_ready: data_ready=%b expected 1", t, data_ready);
            end
            push_frame(tbl[t]);
            @(negedge clk);
            data_valid = 1'b0;
            n = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({ser_out, busy, frame_done} !== {e.ser, e.busy, e.fd}) begin
                    fails++;
                    $display("FAIL fmt%0d clk%0d: ser/busy/fd=%b%b%b expected %b%b%b",
                             t, n, ser_out, busy, frame_done, e.ser, e.busy, e.fd);
                end
                n++;
                @(negedge clk);
            end
            tests++;
            if ({ser_out, busy, frame_done} !== 3'b100) begin
                fails++;
                $display("FAIL fmt%0d_idle: ser/busy/fd=%b%b%b expected 100", t, ser_out, busy, frame_done);
            end
        end
    endtask

    task automatic test_cfg_change();
        frm_t f0, f1;
        exp_t e;
        int   n;
        f0 = '{8'hC3, 4'd8, 1'b0, 1'b0, 1'b0, 6'd1};
        f1 = '{8'h6E, 4'd6, 1'b1, 1'b1, 1'b1, 6'd2};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            set_in(t == 0 ? f0 : f1);
            data_valid = 1'b1;
            tests++;
            if (data_ready !== 1'b1) begin
                fails++;
                $display("FAIL cfg%0d_ready: data_ready=%b expected 1", t, data_ready);
            end
            push_frame(t == 0 ? f0 : f1);
            @(negedge clk);
            data_valid = 1'b0;
            n = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({ser_out, busy, frame_done} !== {e.ser, e.busy, e.fd}) begin
                    fails++;
                    $display("FAIL cfg%0d clk%0d: ser/busy/fd=%b%b%b expected %b%b%b",
                             t, n, ser_out, busy, frame_done, e.ser, e.busy, e.fd);
                end
                // Scramble every input while the frame is on the line.
                data_in  = 8'($urandom);
                data_len = 4'($urandom);
                par_en   = 1'($urandom);
                par_type = 1'($urandom);
                stop2    = 1'($urandom);
                prescale = 6'($urandom);
                n++;
                @(negedge clk);
            end
            tests++;
            if ({ser_out, busy} !== 2'b10) begin
                fails++;
                $display("FAIL cfg%0d_idle: ser/busy=%b%b expected 10", t, ser_out, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        frm_t f0, f1;
        exp_t e;
        int   k;
        f0 = '{8'h01, 4'd8, 1'b0, 1'b0, 1'b0, 6'd0};
        f1 = '{8'h80, 4'd8, 1'b0, 1'b0, 1'b0, 6'd0};
        @(negedge clk);
        set_in(f0);
        data_valid = 1'b1;
        tests++;
        if (data_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready0: data_ready=%b expected 1", data_ready);
        end
        push_frame(f0);
        @(negedge clk);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({ser_out, busy, frame_done} !== {e.ser, e.busy, e.fd}) begin
                fails++;
                $display("FAIL b2b clk%0d: ser/busy/fd=%b%b%b expected %b%b%b",
                         k, ser_out, busy, frame_done, e.ser, e.busy, e.fd);
            end
            if (k == 0) begin
                data_in = f1.d;
                tests++;
                if (data_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready1: data_ready=%b expected 1", data_ready);
                end
                push_frame(f1);
            end else begin
                data_valid = 1'b0;
                tests++;
                if (data_ready !== (k >= 10)) begin
                    fails++;
                    $display("FAIL b2b_ready clk%0d: data_ready=%b expected %b", k, data_ready, (k >= 10));
                end
            end
            k++;
            @(negedge clk);
        end
        tests++;
        if ({ser_out, busy, data_ready} !== 3'b101) begin
            fails++;
            $display("FAIL b2b_idle: ser/busy/ready=%b%b%b expected 101", ser_out, busy, data_ready);
        end
    endtask

    task automatic test_reset_mid();
        frm_t f0;
        exp_t e;
        int   k;
        f0 = '{8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 6'd3};
        @(negedge clk);
        set_in(f0);
        data_valid = 1'b1;
        push_frame(f0);
        @(negedge clk);
        k = 0;
        while (k <= 17) begin
            e = exp_q.pop_front();
            tests++;
            if ({ser_out, busy} !== {e.ser, e.busy}) begin
                fails++;
                $display("FAIL rstmid clk%0d: ser/busy=%b%b expected %b%b", k, ser_out, busy, e.ser, e.busy);
            end
            if (k == 0) begin
                data_in = 8'hFF;
            end else begin
                data_valid = 1'b0;
                if (k == 1) begin
                    tests++;
                    if (data_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL rstmid_held: data_ready=%b expected 0", data_ready);
                    end
                end
            end
            k++;
            @(negedge clk);
        end
        // Sample 17 is the second clock of data bit 3.
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        tests++;
        if ({ser_out, busy, data_ready} !== 3'b100) begin
            fails++;
            $display("FAIL rstmid_abort: ser/busy/ready=%b%b%b expected 100", ser_out, busy, data_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (data_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_release: data_ready=%b expected 1", data_ready);
        end
        for (int i = 0; i < 40; i++) begin
            tests++;
            if ({ser_out, busy, frame_done} !== 3'b100) begin
                fails++;
                $display("FAIL rstmid_quiet clk%0d: ser/busy/fd=%b%b%b expected 100", i, ser_out, busy, frame_done);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        data_len   = 4'd8;
        par_en     = 1'b0;
        par_type   = 1'b0;
        stop2      = 1'b0;
        prescale   = '0;
        test_reset();
        test_formats();
        test_cfg_change();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
